elevator_dispatcher: RTL and testbench
======================================

Name: elevator_dispatcher

Overview:
- Consumer end of the button-latch interface: reads latched cab/hall requests (active_*_levels) and drives car motion, door and cab position.
- Returns one-cycle inactivate_*_levels pulses when a request is served, clearing the latch in the buttons block.
- Collective (SCAN) policy: keep direction while requests remain ahead, then reverse.
- Car position is tracked internally with per-floor travel and door timers; there is no position sensor.

Parameters:
- FLOORS, 8, number of floors; equals the button vector width.
- FLOOR_BITS, 3, width of current_floor; must satisfy 2^FLOOR_BITS >= FLOORS.
- TRAVEL_CYCLES, 16, clock cycles to move one floor; must be >= 2.
- DOOR_CYCLES, 32, clock cycles the door stays open; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- active_in_levels  input  FLOORS  latched cab requests.
- active_out_up_levels  input  FLOORS  latched hall-up requests.
- active_out_down_levels  input  FLOORS  latched hall-down requests.
- inactivate_in_levels  output  FLOORS  one-cycle clear pulse, cab requests.
- inactivate_out_up_levels  output  FLOORS  one-cycle clear pulse, hall-up requests.
- inactivate_out_down_levels  output  FLOORS  one-cycle clear pulse, hall-down requests.
- current_floor  output  FLOOR_BITS  car position.
- dir_up  output  1  1 = travelling/preferring up, 0 = down.
- motor_up  output  1  car moving up.
- motor_down  output  1  car moving down.
- door_open  output  1  door open.

Behaviour:
- Reset (async, immediate): state IDLE, current_floor=0, dir_up=1, timer=0. All of motor_up, motor_down, door_open and every inactivate_* are 0.
- Derived signals from current inputs, f = current_floor:
  - req = in|up|down.
  - above = any req bit with index > f.
  - below = any req bit with index < f.
  - here = req[f].
- States: IDLE, MOVE, DOOR.
- IDLE:
  - here: go to DOOR; pulse all three inactivate bits at f.
  - else if dir_up=1: above -> MOVE up; else below -> MOVE with dir_up<=0.
  - else (dir_up=0): below -> MOVE down; else above -> MOVE with dir_up<=1.
  - No request: stay in IDLE.
  - Latency: request -> DOOR or MOVE on the next rising edge.
- MOVE:
  - motor_up=dir_up, motor_down=~dir_up.
  - Timer loads TRAVEL_CYCLES-1 on entry and counts down.
  - At timer==0: nf = f±1. Stop at nf if:
    - in[nf], or
    - the direction-matching hall bit at nf (up[nf] when dir_up, down[nf] otherwise), or
    - no requests lie beyond nf in the current direction.
  - Stop: next edge sets current_floor=nf, enters DOOR, pulses inactivate_in[nf] plus the matching hall bit. On a reversal stop (nothing beyond nf) also pulse the opposite hall bit and toggle dir_up.
  - Continue: current_floor=nf, timer reloads, stay in MOVE.
  - The stop decision samples inputs in the timer==0 cycle.
  - Never moves below floor 0 or above FLOORS-1; guaranteed by above/below.
- DOOR:
  - door_open=1; timer loads DOOR_CYCLES-1 on entry.
  - A new in[f] or direction-matching hall bit at f while in DOOR: pulse its inactivate bit on the next edge and reload the timer.
  - Opposite-direction hall bit at f: ignored while door is open; served on a later visit.
  - At timer==0 with no new matching request: go to IDLE, door_open=0.
- Pulses: every inactivate_* bit is high for exactly one cycle, registered, aligned with the state transition edge. A bit never pulses while the corresponding active bit is 0. No pulse in the reset cycle.
- Outputs are mutually exclusive: motor_up, motor_down and door_open are never simultaneously high.
- Reset mid-travel or mid-door: immediate return to reset values; position is lost and restarts at floor 0.

Test Plan:
- Reset, then active_in_levels=8'h01 at floor 0 -> next edge door_open=1 and inactivate_in_levels=8'h01 for exactly 1 cycle; door_open falls after 32 cycles; state back to IDLE.
- From IDLE at floor 0, active_in_levels[5]=1 -> motor_up=1; current_floor increments every 16 cycles; at floor 5 (80 cycles) door_open=1 and inactivate_in_levels=8'h20.
- Moving up with in[5] and out_down[3] set -> passes floor 3 with no pulse; stops at 5; then dir_up=0, returns to 3 and pulses inactivate_out_down_levels=8'h08.
- From floor 0 with out_up[2] and out_down[6] -> stops at 2 with inactivate_out_up_levels=8'h04; continues up; reversal stop at 6 with inactivate_out_down_levels=8'h40 and dir_up=0.
- Door open at floor 4 going up, then in[4] re-asserted -> one inactivate_in_levels=8'h10 pulse and door timer restarts (door open 32 cycles from the pulse). Asserting down[4] instead -> no pulse, door closes on schedule.
- Assert reset at cycle 7 of MOVE toward floor 3 -> same cycle all motor/door outputs 0, current_floor=0, dir_up=1. After release with in[3] still active, travel restarts from floor 0.

Source files
------------

// File: rtl/elevator_dispatcher_if.sv
// Button-latch handshake between the request latches and the elevator dispatcher.
// The dispatcher consumes latched requests and returns one-cycle clear pulses plus car status.
interface elevator_dispatcher_if #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_BITS = 3
);
    logic [FLOORS-1:0]     active_in_levels;
    logic [FLOORS-1:0]     active_out_up_levels;
    logic [FLOORS-1:0]     active_out_down_levels;
    logic [FLOORS-1:0]     inactivate_in_levels;
    logic [FLOORS-1:0]     inactivate_out_up_levels;
    logic [FLOORS-1:0]     inactivate_out_down_levels;
    logic [FLOOR_BITS-1:0] current_floor;
    logic                  dir_up;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;

    modport master (
        output active_in_levels, active_out_up_levels, active_out_down_levels,
        input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
        input  current_floor, dir_up, motor_up, motor_down, door_open
    );

    modport slave (
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
        output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
        output current_floor, dir_up, motor_up, motor_down, door_open
    );
endinterface

// File: rtl/elevator_dispatcher.sv
// Collective (SCAN) elevator dispatcher: tracks car position with travel/door timers,
// drives motor and door, and returns one-cycle clear pulses for served requests.
module elevator_dispatcher #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_BITS    = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_dispatcher_if.slave bus
);
    localparam int TMAX       = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_BITS = $clog2(TMAX);
    localparam logic [TIMER_BITS-1:0] TRAVEL_LOAD = TIMER_BITS'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] DOOR_LOAD   = TIMER_BITS'(DOOR_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] TIMER_ZERO  = {TIMER_BITS{1'b0}};
    localparam logic [FLOORS-1:0]     NO_BITS     = {FLOORS{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FLOOR_BITS-1:0] floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [FLOORS-1:0]     clr_in_q, clr_in_d;
    logic [FLOORS-1:0]     clr_up_q, clr_up_d;
    logic [FLOORS-1:0]     clr_dn_q, clr_dn_d;
    logic                  motor_up_q, motor_up_d;
    logic                  motor_dn_q, motor_dn_d;
    logic                  door_q, door_d;

    logic [FLOORS-1:0]     in_s, up_s, dn_s, req_s;
    logic [FLOOR_BITS-1:0] nf_s;
    logic                  above_s, below_s, here_s;
    logic                  beyond_up_s, beyond_dn_s, beyond_s;
    logic                  match_here_s, stop_s;

    // A bit whose clear pulse is in flight is still set in the latch for one more cycle; treat it as served.
    assign in_s  = bus.active_in_levels       & ~clr_in_q;
    assign up_s  = bus.active_out_up_levels   & ~clr_up_q;
    assign dn_s  = bus.active_out_down_levels & ~clr_dn_q;
    assign req_s = in_s | up_s | dn_s;

    // Neighbour floor and request-position summaries relative to the car and to the next floor.
    always_comb begin
        above_s     = 1'b0;
        below_s     = 1'b0;
        beyond_up_s = 1'b0;
        beyond_dn_s = 1'b0;
        if (dir_q) begin
            nf_s = floor_q + FLOOR_BITS'(1);
        end else begin
            nf_s = floor_q - FLOOR_BITS'(1);
        end
        for (int i = 0; i < FLOORS; i++) begin
            above_s     = above_s     | (req_s[i] & (i > int'(floor_q)));
            below_s     = below_s     | (req_s[i] & (i < int'(floor_q)));
            beyond_up_s = beyond_up_s | (req_s[i] & (i > int'(nf_s)));
            beyond_dn_s = beyond_dn_s | (req_s[i] & (i < int'(nf_s)));
        end
        here_s       = req_s[floor_q];
        beyond_s     = dir_q ? beyond_up_s : beyond_dn_s;
        match_here_s = in_s[floor_q] | (dir_q ? up_s[floor_q] : dn_s[floor_q]);
        stop_s       = in_s[nf_s] | (dir_q ? up_s[nf_s] : dn_s[nf_s]) | ~beyond_s;
    end

    // Next-state, position, direction, timer and clear-pulse decisions.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        clr_in_d = NO_BITS;
        clr_up_d = NO_BITS;
        clr_dn_d = NO_BITS;
        case (state_q)
            IDLE: begin
                if (here_s) begin
                    state_d           = DOOR;
                    timer_d           = DOOR_LOAD;
                    clr_in_d[floor_q] = in_s[floor_q];
                    clr_up_d[floor_q] = up_s[floor_q];
                    clr_dn_d[floor_q] = dn_s[floor_q];
                end else if (dir_q ? above_s : below_s) begin
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                end else if (dir_q ? below_s : above_s) begin
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                    dir_d   = ~dir_q;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (timer_q == TIMER_ZERO) begin
                    floor_d = nf_s;
                    if (stop_s) begin
                        // With nothing further ahead the car turns around here, so both hall calls are served.
                        state_d        = DOOR;
                        timer_d        = DOOR_LOAD;
                        dir_d          = beyond_s ? dir_q : ~dir_q;
                        clr_in_d[nf_s] = in_s[nf_s];
                        clr_up_d[nf_s] = up_s[nf_s] & (dir_q | ~beyond_s);
                        clr_dn_d[nf_s] = dn_s[nf_s] & (~dir_q | ~beyond_s);
                    end else begin
                        timer_d = TRAVEL_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TIMER_BITS'(1);
                end
            end
            DOOR: begin
                if (match_here_s) begin
                    timer_d           = DOOR_LOAD;
                    clr_in_d[floor_q] = in_s[floor_q];
                    clr_up_d[floor_q] = up_s[floor_q] & dir_q;
                    clr_dn_d[floor_q] = dn_s[floor_q] & ~dir_q;
                end else if (timer_q == TIMER_ZERO) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        motor_up_d = (state_d == MOVE) & dir_d;
        motor_dn_d = (state_d == MOVE) & ~dir_d;
        door_d     = (state_d == DOOR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            floor_q    <= {FLOOR_BITS{1'b0}};
            dir_q      <= 1'b1;
            timer_q    <= TIMER_ZERO;
            clr_in_q   <= NO_BITS;
            clr_up_q   <= NO_BITS;
            clr_dn_q   <= NO_BITS;
            motor_up_q <= 1'b0;
            motor_dn_q <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            clr_in_q   <= clr_in_d;
            clr_up_q   <= clr_up_d;
            clr_dn_q   <= clr_dn_d;
            motor_up_q <= motor_up_d;
            motor_dn_q <= motor_dn_d;
            door_q     <= door_d;
        end
    end

    assign bus.inactivate_in_levels       = clr_in_q;
    assign bus.inactivate_out_up_levels   = clr_up_q;
    assign bus.inactivate_out_down_levels = clr_dn_q;
    assign bus.current_floor              = floor_q;
    assign bus.dir_up                     = dir_q;
    assign bus.motor_up                   = motor_up_q;
    assign bus.motor_down                 = motor_dn_q;
    assign bus.door_open                  = door_q;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher: the bench plays the button latches, clearing a
// request bit once its clear pulse has been seen, and checks position, motion and pulses.
module tb_elevator_dispatcher;
    logic       clk = 1'b0;
    logic       reset;
    int         tests = 0;
    int         fails = 0;
    int         n;
    logic [7:0] acc_in, acc_up, acc_dn;

    elevator_dispatcher_if #(.FLOORS(8), .FLOOR_BITS(3)) bus ();

    elevator_dispatcher #(
        .FLOORS(8), .FLOOR_BITS(3), .TRAVEL_CYCLES(16), .DOOR_CYCLES(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge, then clear latched bits that were pulsed.
    task automatic tick();
        @(posedge clk);
        #1;
        acc_in |= bus.inactivate_in_levels;
        acc_up |= bus.inactivate_out_up_levels;
        acc_dn |= bus.inactivate_out_down_levels;
        check("pulse_without_request",
              32'({bus.inactivate_in_levels & ~bus.active_in_levels,
                   bus.inactivate_out_up_levels & ~bus.active_out_up_levels,
                   bus.inactivate_out_down_levels & ~bus.active_out_down_levels}), 32'd0);
        check("outputs_exclusive",
              32'((bus.motor_up & bus.motor_down) | (bus.motor_up & bus.door_open) |
                  (bus.motor_down & bus.door_open)), 32'd0);
        bus.active_in_levels       &= ~bus.inactivate_in_levels;
        bus.active_out_up_levels   &= ~bus.inactivate_out_up_levels;
        bus.active_out_down_levels &= ~bus.inactivate_out_down_levels;
    endtask

    task automatic clear_acc();
        acc_in = 8'h00;
        acc_up = 8'h00;
        acc_dn = 8'h00;
    endtask

    // cond 0: door open, 1: door closed, 2: motor running
    task automatic run_until(input int cond, input int budget, input string tag, output int cnt);
        logic hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < budget) begin
            tick();
            cnt++;
            case (cond)
                0:       hit = bus.door_open;
                1:       hit = ~bus.door_open;
                2:       hit = bus.motor_up | bus.motor_down;
                default: hit = 1'b1;
            endcase
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.active_in_levels       = 8'h00;
        bus.active_out_up_levels   = 8'h00;
        bus.active_out_down_levels = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        clear_acc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.active_in_levels       = 8'h00;
        bus.active_out_up_levels   = 8'h00;
        bus.active_out_down_levels = 8'h00;
        clear_acc();
        tick();
        check("reset_status", 32'({bus.current_floor, bus.dir_up, bus.motor_up, bus.motor_down, bus.door_open}),
              32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("reset_pulses", 32'({bus.inactivate_in_levels, bus.inactivate_out_up_levels,
                                   bus.inactivate_out_down_levels}), 32'd0);
        tick();
        reset = 1'b0;

        // Cab call at the current floor opens the door on the next edge.
        bus.active_in_levels = 8'h01;
        tick();
        check("t1_door_open", 32'(bus.door_open), 32'd1);
        check("t1_pulse_in", 32'(bus.inactivate_in_levels), 32'h01);
        tick();
        check("t1_pulse_one_cycle", 32'(bus.inactivate_in_levels), 32'h00);
        repeat (30) tick();
        check("t1_door_cycle32", 32'(bus.door_open), 32'd1);
        tick();
        check("t1_door_closed", 32'({bus.door_open, bus.motor_up, bus.motor_down}), 32'd0);

        // Travel up to 5, passing a down-call at 3, then come back for it.
        do_reset();
        bus.active_in_levels       = 8'h20;
        bus.active_out_down_levels = 8'h08;
        tick();
        check("t3_motor_up", 32'({bus.motor_up, bus.current_floor}), 32'({1'b1, 3'd0}));
        repeat (15) tick();
        check("t3_floor_c16", 32'(bus.current_floor), 32'd0);
        tick();
        check("t3_floor_c17", 32'(bus.current_floor), 32'd1);
        repeat (32) tick();
        check("t3_pass_floor3", 32'({bus.current_floor, bus.motor_up, bus.door_open}), 32'({3'd3, 1'b1, 1'b0}));
        check("t3_no_pulse_at3", 32'(acc_dn), 32'h00);
        repeat (31) tick();
        check("t3_floor4_moving", 32'({bus.current_floor, bus.door_open}), 32'({3'd4, 1'b0}));
        tick();
        check("t3_stop5", 32'({bus.current_floor, bus.door_open, bus.motor_up, bus.dir_up}),
              32'({3'd5, 1'b1, 1'b0, 1'b0}));
        check("t3_pulse_in5", 32'(bus.inactivate_in_levels), 32'h20);
        run_until(2, 40, "t3_depart5", n);
        check("t3_depart_cycles", 32'(n), 32'd33);
        check("t3_motor_down", 32'({bus.motor_down, bus.current_floor}), 32'({1'b1, 3'd5}));
        clear_acc();
        run_until(0, 40, "t3_arrive3", n);
        check("t3_arrive_cycles", 32'(n), 32'd32);
        check("t3_at3", 32'({bus.current_floor, bus.dir_up}), 32'({3'd3, 1'b1}));
        check("t3_pulse_down3", 32'(bus.inactivate_out_down_levels), 32'h08);

        // Hall-up stop at 2, then reversal stop at 6 for a down call.
        do_reset();
        bus.active_out_up_levels   = 8'h04;
        bus.active_out_down_levels = 8'h40;
        run_until(0, 60, "t4_arrive2", n);
        check("t4_arrive2_cycles", 32'(n), 32'd33);
        check("t4_at2", 32'({bus.current_floor, bus.dir_up}), 32'({3'd2, 1'b1}));
        check("t4_pulse_up2", 32'({bus.inactivate_out_up_levels, acc_dn}), 32'({8'h04, 8'h00}));
        run_until(2, 40, "t4_depart2", n);
        check("t4_depart_up", 32'({n[7:0], bus.motor_up}), 32'({8'd33, 1'b1}));
        run_until(0, 80, "t4_arrive6", n);
        check("t4_arrive6_cycles", 32'(n), 32'd64);
        check("t4_at6", 32'({bus.current_floor, bus.dir_up}), 32'({3'd6, 1'b0}));
        check("t4_pulse_down6", 32'(bus.inactivate_out_down_levels), 32'h40);

        // Reset in the middle of a downward trip from 6 toward 3.
        bus.active_in_levels = 8'h08;
        run_until(2, 40, "t6_depart6", n);
        check("t6_depart_down", 32'({n[7:0], bus.motor_down, bus.current_floor}), 32'({8'd33, 1'b1, 3'd6}));
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("t6_async_reset", 32'({bus.current_floor, bus.dir_up, bus.motor_up, bus.motor_down, bus.door_open}),
              32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        tick();
        reset = 1'b0;
        run_until(2, 5, "t6_restart", n);
        check("t6_restart_up", 32'({n[7:0], bus.motor_up, bus.current_floor}), 32'({8'd1, 1'b1, 3'd0}));
        run_until(0, 60, "t6_arrive3", n);
        check("t6_arrive3_cycles", 32'(n), 32'd48);
        check("t6_pulse_in3", 32'({bus.current_floor, bus.inactivate_in_levels}), 32'({3'd3, 8'h08}));

        // Door at 4 heading up: a repeated cab call restarts the door timer.
        do_reset();
        bus.active_in_levels = 8'h90;
        run_until(0, 80, "t5_arrive4", n);
        check("t5_arrive4_cycles", 32'(n), 32'd65);
        check("t5_at4", 32'({bus.current_floor, bus.dir_up, bus.inactivate_in_levels}), 32'({3'd4, 1'b1, 8'h10}));
        repeat (10) tick();
        bus.active_in_levels |= 8'h10;
        tick();
        check("t5_repulse_in4", 32'({bus.door_open, bus.inactivate_in_levels}), 32'({1'b1, 8'h10}));
        run_until(1, 60, "t5_close_after_repulse", n);
        check("t5_door_restart_len", 32'(n), 32'd32);

        // Door at 4 heading up: an opposite hall call is left for the next visit.
        do_reset();
        bus.active_in_levels = 8'h90;
        run_until(0, 80, "t5b_arrive4", n);
        check("t5b_arrive4_cycles", 32'(n), 32'd65);
        repeat (5) tick();
        bus.active_out_down_levels = 8'h10;
        clear_acc();
        run_until(1, 60, "t5b_close", n);
        check("t5b_close_on_schedule", 32'(n), 32'd27);
        check("t5b_no_down_pulse", 32'({acc_dn, acc_in}), 32'd0);
        tick();
        check("t5b_served_later", 32'({bus.door_open, bus.current_floor, bus.inactivate_out_down_levels}),
              32'({1'b1, 3'd4, 8'h10}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
